// File: rtl/multicast_bp_if.sv
// multicast_bp_if: upstream, ROM and per-port output signals of the multicast fork.
// The master modport is the multicast block; the slave modport is its surroundings.
interface multicast_bp_if #(
  parameter int N       = 15486,
  parameter int M       = 80,
  parameter int DATA_W  = 64,
  parameter int IDX_W   = 7,
  parameter int MAX_FAN = 4
);
  localparam int SEQ_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_FAN + 1);
  localparam int ROM_W = CNT_W + MAX_FAN * IDX_W;

  logic [DATA_W-1:0] s_data;
  logic [SEQ_W-1:0]  s_seq;
  logic              s_valid;
  logic              s_ready;
  logic              rom_en;
  logic [SEQ_W-1:0]  rom_addr;
  logic [ROM_W-1:0]  rom_q;
  logic [DATA_W-1:0] m_data;
  logic [M-1:0]      m_valid;
  logic [M-1:0]      m_ready;

  modport master (
    input  s_data, s_seq, s_valid, rom_q, m_ready,
    output s_ready, rom_en, rom_addr, m_data, m_valid
  );

  modport slave (
    output s_data, s_seq, s_valid, rom_q, m_ready,
    input  s_ready, rom_en, rom_addr, m_data, m_valid
  );
endinterface

// File: rtl/multicast_bp.sv
// multicast_bp: ROM-driven multicast fork with independent per-port backpressure.
// Define MULTICAST_STATS_EN to add the stat_pkt / stat_drop / stat_stall counters.
module multicast_bp #(
  parameter int N       = 15486,
  parameter int M       = 80,
  parameter int DATA_W  = 64,
  parameter int IDX_W   = 7,
  parameter int MAX_FAN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multicast_bp_if.master       bus
`ifdef MULTICAST_STATS_EN
  ,
  output logic [31:0]          stat_pkt,
  output logic [31:0]          stat_drop,
  output logic [31:0]          stat_stall
`endif
);
  localparam int SEQ_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_FAN + 1);
  localparam int ROM_W = CNT_W + MAX_FAN * IDX_W;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] raw);
    return (int'(raw) > MAX_FAN) ? CNT_W'(MAX_FAN) : raw;
  endfunction

  // Unused slots, out-of-range indices and duplicates all fall out of the OR into the mask.
  function automatic logic [M-1:0] decode_mask(input logic [ROM_W-1:0] word);
    logic [M-1:0]     mask;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    mask = '0;
    cnt  = sat_count(word[CNT_W-1:0]);
    for (int k = 0; k < MAX_FAN; k++) begin
      idx = word[CNT_W + k*IDX_W +: IDX_W];
      if (k < int'(cnt)) begin
        for (int j = 0; j < M; j++) begin
          if (int'(idx) == j) mask[j] = 1'b1;
        end
      end
    end
    return mask;
  endfunction

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [M-1:0]      mask_p0;
  logic [M-1:0]      pend_p1;
  logic [DATA_W-1:0] data_p1;
  logic [M-1:0]      hs;
  logic [SEQ_W-1:0]  addr;
  logic              advance;
  logic              accept;

  assign hs      = pend_p1 & bus.m_ready;
  // An idle O stage has no pending bits, so "idle or finishing" reduces to this.
  assign advance = vld_p0 & ~|(pend_p1 & ~hs);
  assign bus.s_ready = ~vld_p0 | advance;
  assign accept  = bus.s_valid & bus.s_ready & ~rst;
  assign addr    = bus.s_seq;
  assign bus.rom_en   = accept;
  assign bus.rom_addr = addr;
  assign mask_p0 = decode_mask(bus.rom_q);
  assign bus.m_valid  = pend_p1;
  assign bus.m_data   = data_p1;

  // ---- stage L (p0): packet waits here while the ROM word is returned ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
    end else if (advance) begin
      vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) data_p0 <= bus.s_data;
  end

  // ---- stage O (p1): per-port pending bits retire as each port handshakes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_p1 <= '0;
      data_p1 <= '0;
    end else if (advance) begin
      pend_p1 <= mask_p0;
      data_p1 <= data_p0;
    end else begin
      pend_p1 <= pend_p1 & ~hs;
    end
  end

`ifdef MULTICAST_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt   <= '0;
      stat_drop  <= '0;
      stat_stall <= '0;
    end else begin
      if (accept) stat_pkt <= stat_pkt + 32'd1;
      if (advance && mask_p0 == '0) stat_drop <= stat_drop + 32'd1;
      if (bus.s_valid && !bus.s_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multicast_bp.sv
// tb_multicast_bp: directed and randomized checks of multicast_bp against a
// per-port delivery-queue model built from the ROM entry rules.
module tb_multicast_bp;
  localparam int N       = 15486;
  localparam int M       = 80;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = 7;
  localparam int MAX_FAN = 4;
  localparam int CNT_W   = $clog2(MAX_FAN + 1);
  localparam int ROM_W   = CNT_W + MAX_FAN * IDX_W;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicast_bp_if #(.N(N), .M(M), .DATA_W(DATA_W), .IDX_W(IDX_W), .MAX_FAN(MAX_FAN)) bus ();

`ifdef MULTICAST_STATS_EN
  logic [31:0] stat_pkt, stat_drop, stat_stall;
`endif

  multicast_bp #(.N(N), .M(M), .DATA_W(DATA_W), .IDX_W(IDX_W), .MAX_FAN(MAX_FAN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MULTICAST_STATS_EN
    ,
    .stat_pkt   (stat_pkt),
    .stat_drop  (stat_drop),
    .stat_stall (stat_stall)
`endif
  );

  // Synchronous ROM model: word appears the cycle after rom_en and then holds.
  logic [ROM_W-1:0] rom_mem [N];
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_q <= rom_mem[bus.rom_addr];
  end

  function automatic logic [ROM_W-1:0] mk_entry(int cnt, int a, int b, int c, int d);
    logic [ROM_W-1:0] w;
    int ix[4];
    ix = '{a, b, c, d};
    w = '0;
    w[CNT_W-1:0] = CNT_W'(cnt);
    for (int k = 0; k < 4; k++) w[CNT_W + k*IDX_W +: IDX_W] = IDX_W'(ix[k]);
    return w;
  endfunction

  // Set of ports a ROM word sends to.
  function automatic logic [M-1:0] ref_dests(logic [ROM_W-1:0] w);
    logic [M-1:0] d;
    int n;
    int p;
    d = '0;
    n = int'(w[CNT_W-1:0]);
    if (n > MAX_FAN) n = MAX_FAN;
    for (int k = 0; k < n; k++) begin
      p = int'(w[CNT_W + k*IDX_W +: IDX_W]);
      if (p < M) d[p] = 1'b1;
    end
    return d;
  endfunction

  logic [DATA_W-1:0] exp_q [M][$];
  logic [DATA_W-1:0] obs_q [M][$];
  logic [M-1:0]      mon_dests;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_valid && bus.s_ready) begin
        mon_dests = ref_dests(rom_mem[bus.s_seq]);
        for (int i = 0; i < M; i++) if (mon_dests[i]) exp_q[i].push_back(bus.s_data);
      end
      for (int i = 0; i < M; i++) if (bus.m_valid[i] && bus.m_ready[i]) obs_q[i].push_back(bus.m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_valid = 1'b0;
    bus.s_seq   = '0;
    bus.s_data  = '0;
    bus.m_ready = '1;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < M; i++) begin
      exp_q[i].delete();
      obs_q[i].delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.s_valid = 1'b1;
    bus.s_seq   = 5;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== '0) begin n_err++; $display("FAIL reset_m_valid got %h want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== '0) begin n_err++; $display("FAIL reset_m_data got %h want 0", bus.m_data); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
    n_cmp++; if (bus.rom_en !== 1'b0) begin n_err++; $display("FAIL reset_rom_en got %b want 0", bus.rom_en); end
`ifdef MULTICAST_STATS_EN
    n_cmp++; if ({stat_pkt, stat_drop, stat_stall} !== 96'd0) begin n_err++; $display("FAIL reset_stats got %h %h %h want 0", stat_pkt, stat_drop, stat_stall); end
`endif
    tick();
    bus.s_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [M-1:0] want;
    want = '0; want[3] = 1'b1; want[70] = 1'b1;
    rom_mem[5] = mk_entry(2, 3, 70, 0, 0);
    tick();
    bus.s_valid = 1'b1; bus.s_seq = 5; bus.s_data = 64'hA5;
    @(negedge clk);
    n_cmp++; if ({bus.s_ready, bus.rom_en, bus.rom_addr} !== {1'b1, 1'b1, 14'd5}) begin n_err++; $display("FAIL single_rom_req got rdy=%b en=%b addr=%0d want 1 1 5", bus.s_ready, bus.rom_en, bus.rom_addr); end
    tick();
    bus.s_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== '0) begin n_err++; $display("FAIL single_t1 m_valid got %h want 0", bus.m_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== want || bus.m_data !== 64'hA5) begin n_err++; $display("FAIL single_t2 got %h/%h want %h/a5", bus.m_valid, bus.m_data, want); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== '0) begin n_err++; $display("FAIL single_t3 m_valid got %h want 0", bus.m_valid); end
    tick();
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] pd [100];
    logic [M-1:0] want;
    clear_sb();
    for (int i = 0; i < 100; i++) begin
      rom_mem[100 + i] = mk_entry(1, i % M, 0, 0, 0);
      pd[i] = {$urandom, $urandom};
    end
    for (int c = 0; c < 104; c++) begin
      tick();
      if (c < 100) begin
        bus.s_valid = 1'b1; bus.s_seq = 14'(100 + c); bus.s_data = pd[c];
      end else begin
        bus.s_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 100) begin
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready cycle %0d got %b want 1", c, bus.s_ready); end
      end
      if (c >= 2 && c < 102) begin
        want = '0; want[(c - 2) % M] = 1'b1;
        n_cmp++; if (bus.m_valid !== want || bus.m_data !== pd[c - 2]) begin n_err++; $display("FAIL stream_out cycle %0d got %h/%h want %h/%h", c, bus.m_valid, bus.m_data, want, pd[c - 2]); end
      end
    end
    for (int i = 0; i < M; i++) begin
      n_cmp++;
      if (obs_q[i].size() != exp_q[i].size()) begin n_err++; $display("FAIL stream_count port %0d got %0d want %0d", i, obs_q[i].size(), exp_q[i].size()); end
      else for (int k = 0; k < obs_q[i].size(); k++) begin
        n_cmp++; if (obs_q[i][k] !== exp_q[i][k]) begin n_err++; $display("FAIL stream_order port %0d #%0d got %h want %h", i, k, obs_q[i][k], exp_q[i][k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] pd [3];
    logic [M-1:0] v;
    logic [DATA_W-1:0] d;
    logic r;
    int sent;
    sent = 0;
    for (int i = 0; i < 3; i++) begin
      rom_mem[10 + i] = mk_entry(3, 0, 1, 2, 0);
      pd[i] = {$urandom, $urandom};
    end
    for (int c = 0; c < 17; c++) begin
      tick();
      bus.m_ready = '1;
      if (c < 12) bus.m_ready[1] = 1'b0;
      if (sent < 3) begin
        bus.s_valid = 1'b1; bus.s_seq = 14'(10 + sent); bus.s_data = pd[sent];
      end else begin
        bus.s_valid = 1'b0;
      end
      @(negedge clk);
      v = '0; d = bus.m_data; r = bus.s_ready;
      if (c == 2) begin v = M'(3'b111); d = pd[0]; r = 1'b0; end
      else if (c >= 3 && c <= 11) begin v = M'(3'b010); d = pd[0]; r = 1'b0; end
      else if (c == 12) begin v = M'(3'b010); d = pd[0]; r = 1'b1; end
      else if (c == 13) begin v = M'(3'b111); d = pd[1]; end
      else if (c == 14) begin v = M'(3'b111); d = pd[2]; end
      if (c >= 2) begin
        n_cmp++;
        if ({bus.m_valid, bus.m_data, bus.s_ready} !== {v, d, r}) begin
          n_err++; $display("FAIL backpressure cycle %0d got %h/%h/%b want %h/%h/%b", c, bus.m_valid, bus.m_data, bus.s_ready, v, d, r);
        end
      end
      if (bus.s_valid && bus.s_ready) sent++;
    end
    idle_inputs();
  endtask

  task automatic test_drop_dup();
    logic [DATA_W-1:0] pd [2];
    logic [M-1:0] want;
    clear_sb();
    rom_mem[20] = mk_entry(0, 1, 2, 3, 4);
    rom_mem[21] = mk_entry(4, 7, 7, 90, 7);
    pd[0] = {$urandom, $urandom};
    pd[1] = {$urandom, $urandom};
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c < 2) begin bus.s_valid = 1'b1; bus.s_seq = 14'(20 + c); bus.s_data = pd[c]; end
      else bus.s_valid = 1'b0;
      @(negedge clk);
      if (c < 2) begin
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready cycle %0d got %b want 1", c, bus.s_ready); end
      end
      want = '0;
      if (c == 3) want[7] = 1'b1;
      if (c >= 2) begin
        n_cmp++; if (bus.m_valid !== want || (c == 3 && bus.m_data !== pd[1])) begin n_err++; $display("FAIL drop_dup cycle %0d got %h/%h want %h/%h", c, bus.m_valid, bus.m_data, want, pd[1]); end
      end
    end
    for (int i = 0; i < M; i++) begin
      n_cmp++;
      if (obs_q[i].size() != exp_q[i].size()) begin n_err++; $display("FAIL drop_count port %0d got %0d want %0d", i, obs_q[i].size(), exp_q[i].size()); end
      else for (int k = 0; k < obs_q[i].size(); k++) begin
        n_cmp++; if (obs_q[i][k] !== exp_q[i][k]) begin n_err++; $display("FAIL drop_data port %0d got %h want %h", i, obs_q[i][k], exp_q[i][k]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [M-1:0] both, only6;
    logic [DATA_W-1:0] p1;
    both = '0; both[5] = 1'b1; both[6] = 1'b1;
    only6 = '0; only6[6] = 1'b1;
    p1 = {$urandom, $urandom};
    rom_mem[40] = mk_entry(2, 5, 6, 0, 0);
    rom_mem[41] = mk_entry(2, 6, 5, 0, 0);
    tick();
    bus.m_ready[6] = 1'b0;
    bus.s_valid = 1'b1; bus.s_seq = 40; bus.s_data = {$urandom, $urandom};
    tick();
    bus.s_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== both) begin n_err++; $display("FAIL midflight_pre got %h want %h", bus.m_valid, both); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== only6) begin n_err++; $display("FAIL midflight_stall got %h want %h", bus.m_valid, only6); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== '0 || bus.s_ready !== 1'b1) begin n_err++; $display("FAIL midflight_reset got %h/%b want 0/1", bus.m_valid, bus.s_ready); end
`ifdef MULTICAST_STATS_EN
    n_cmp++; if ({stat_pkt, stat_drop, stat_stall} !== 96'd0) begin n_err++; $display("FAIL midflight_stats got %h %h %h want 0", stat_pkt, stat_drop, stat_stall); end
`endif
    bus.m_ready = '1;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (bus.m_valid !== '0) begin n_err++; $display("FAIL midflight_residue cycle %0d got %h want 0", c, bus.m_valid); end
    end
    tick();
    bus.s_valid = 1'b1; bus.s_seq = 41; bus.s_data = p1;
    tick();
    bus.s_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== both || bus.m_data !== p1) begin n_err++; $display("FAIL midflight_next got %h/%h want %h/%h", bus.m_valid, bus.m_data, both, p1); end
    tick();
  endtask

  task automatic test_clamp();
    logic [M-1:0] want;
    want = '0;
    for (int i = 1; i <= 4; i++) want[i] = 1'b1;
    rom_mem[50] = mk_entry(7, 1, 2, 3, 4);
    rst = 1'b1; idle_inputs();
    tick();
    rst = 1'b0;
    bus.s_valid = 1'b1; bus.s_seq = 50; bus.s_data = 64'h0123_4567_89AB_CDEF;
    tick();
    bus.s_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== want || bus.m_data !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL clamp_out got %h/%h want %h/0123456789abcdef", bus.m_valid, bus.m_data, want); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== '0) begin n_err++; $display("FAIL clamp_after got %h want 0", bus.m_valid); end
`ifdef MULTICAST_STATS_EN
    n_cmp++; if (stat_pkt !== 32'd1 || stat_drop !== 32'd0) begin n_err++; $display("FAIL clamp_stats got pkt=%0d drop=%0d want 1 0", stat_pkt, stat_drop); end
`endif
    tick();
  endtask

  task automatic test_random();
    logic [M-1:0] hold;
    logic [DATA_W-1:0] hold_data;
    logic pending;
    hold = '0; hold_data = '0; pending = 1'b0;
    clear_sb();
    for (int a = 200; a < 264; a++) begin
      rom_mem[a] = mk_entry($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 85),
                            $urandom_range(0, 85), $urandom_range(0, 79));
    end
    for (int c = 0; c < 620; c++) begin
      tick();
      if (!pending) begin
        if (c < 600 && $urandom_range(0, 9) < 7) begin
          bus.s_valid = 1'b1; bus.s_seq = 14'($urandom_range(200, 263)); bus.s_data = {$urandom, $urandom};
        end else begin
          bus.s_valid = 1'b0;
        end
      end
      bus.m_ready = (c < 600) ? (M'({$urandom, $urandom, $urandom}) | M'({$urandom, $urandom, $urandom})) : '1;
      @(negedge clk);
      n_cmp++;
      if (((bus.m_valid & hold) !== hold) || (hold != '0 && bus.m_data !== hold_data)) begin
        n_err++; $display("FAIL random_hold cycle %0d got %h/%h want held %h/%h", c, bus.m_valid, bus.m_data, hold, hold_data);
      end
      hold = bus.m_valid & ~bus.m_ready;
      hold_data = bus.m_data;
      pending = bus.s_valid && !bus.s_ready;
    end
    n_cmp++; if (bus.m_valid !== '0) begin n_err++; $display("FAIL random_drain got %h want 0", bus.m_valid); end
    for (int i = 0; i < M; i++) begin
      n_cmp++;
      if (obs_q[i].size() != exp_q[i].size()) begin n_err++; $display("FAIL random_count port %0d got %0d want %0d", i, obs_q[i].size(), exp_q[i].size()); end
      else for (int k = 0; k < obs_q[i].size(); k++) begin
        n_cmp++; if (obs_q[i][k] !== exp_q[i][k]) begin n_err++; $display("FAIL random_order port %0d #%0d got %h want %h", i, k, obs_q[i][k], exp_q[i][k]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_drop_dup();
    test_reset_midflight();
    test_clamp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
